// File: rtl/dataram_access_ctrl.sv
// dataram_access_ctrl
// Sequencer between a CPU-side data-RAM request and the 8051 internal data RAM port.
// A request is either a direct byte, a register Rn, an indirect @Ri or a bit access.
// The block resolves the final RAM address:
//  - register-bank base for Rn
//  - pointer fetch for @Ri
//  - byte/bit-position split for bit addresses
// It then runs exactly one RAM cycle (two for @Ri) and returns a one-cycle done pulse.
// Addresses that land above RAM_TOP (SFR space) finish with err=1 and never touch the RAM.
//
// Ports
//  clk, rst              clock and synchronous active-high reset
//  req / ready           request handshake; accepted when both are high on a rising edge
//  mode, we, opnd, rs    request descriptor (00 direct, 01 Rn, 10 @Ri, 11 bit)
//  wdata, wbit           write data for byte / bit writes
//  rdata, rbit           last completed byte / bit read result
//  done, err             completion pulse and its out-of-range flag
//  ram_*                 RAM port: cs (low active), rw (1=read), bb (1=byte), addr, one-hot pos,
//                        din/bin write data, dout/bout read data
module dataram_access_ctrl #(
    parameter logic [7:0] RAM_TOP = 8'h7F,
    parameter int         RD_LAT  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    output logic       ready,
    input  logic [1:0] mode,
    input  logic       we,
    input  logic [7:0] opnd,
    input  logic [1:0] rs,
    input  logic [7:0] wdata,
    input  logic       wbit,
    output logic [7:0] rdata,
    output logic       rbit,
    output logic       done,
    output logic       err,
    output logic       ram_cs,
    output logic       ram_rw,
    output logic       ram_bb,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_pos,
    output logic [7:0] ram_din,
    output logic       ram_bin,
    input  logic [7:0] ram_dout,
    input  logic       ram_bout
);

    typedef enum logic [2:0] {S_IDLE, S_PTR, S_PWAIT, S_ACC, S_RWAIT, S_DONE} state_t;

    state_t     state_reg, state_next;
    logic [1:0] cnt_reg, cnt_next;
    logic       we_reg, we_next;
    logic       bit_reg, bit_next;
    logic [7:0] addr_reg, addr_next;
    logic [7:0] pos_reg, pos_next;
    logic [7:0] wdata_reg, wdata_next;
    logic       wbit_reg, wbit_next;
    logic       perr_reg, perr_next;
    logic [7:0] rdata_reg, rdata_next;
    logic       rbit_reg, rbit_next;
    logic       ready_reg, ready_next;
    logic       done_reg, done_next;
    logic       err_reg, err_next;
    logic       cs_reg, cs_next;
    logic       rw_reg, rw_next;
    logic       bb_reg, bb_next;
    logic [7:0] ram_addr_reg, ram_addr_next;
    logic [7:0] ram_pos_reg, ram_pos_next;
    logic [7:0] din_reg, din_next;
    logic       bin_reg, bin_next;

    // Address resolution of the incoming request
    logic [7:0] res_addr;
    logic [7:0] res_pos;
    logic       res_bit;
    logic       res_ind;
    logic       res_err;

    always_comb begin
        res_addr = opnd;
        res_pos  = 8'hFF;
        res_bit  = 1'b0;
        res_ind  = 1'b0;
        res_err  = 1'b0;
        case (mode)
            2'b00: res_err = (opnd > RAM_TOP);
            2'b01: begin
                res_addr = {3'b000, rs, opnd[2:0]};
                res_err  = (res_addr > RAM_TOP);
            end
            2'b10: begin
                // address of the pointer register Ri, not the final target
                res_addr = {3'b000, rs, 2'b00, opnd[0]};
                res_ind  = 1'b1;
                res_err  = (res_addr > RAM_TOP);
            end
            default: begin
                // bit-addressable area starts at byte 8'h20; b[7]=1 is SFR bit space
                res_bit  = 1'b1;
                res_addr = 8'h20 + {4'b0000, opnd[6:3]};
                res_pos  = 8'd1 << opnd[2:0];
                res_err  = opnd[7];
            end
        endcase
    end

    // Last wait cycle: the RAM data issued RD_LAT cycles ago is valid now
    logic lat_last;
    assign lat_last = (cnt_reg == 2'(RD_LAT - 1));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        we_next    = we_reg;
        bit_next   = bit_reg;
        addr_next  = addr_reg;
        pos_next   = pos_reg;
        wdata_next = wdata_reg;
        wbit_next  = wbit_reg;
        perr_next  = perr_reg;
        rdata_next = rdata_reg;
        rbit_next  = rbit_reg;

        case (state_reg)
            S_IDLE: begin
                if (req) begin
                    we_next    = we;
                    bit_next   = res_bit;
                    addr_next  = res_addr;
                    pos_next   = res_pos;
                    wdata_next = wdata;
                    wbit_next  = wbit;
                    perr_next  = res_err;
                    if (res_err)
                        state_next = S_DONE;
                    else if (res_ind)
                        state_next = S_PTR;
                    else
                        state_next = S_ACC;
                end
            end
            S_PTR: begin
                cnt_next   = 2'd0;
                state_next = S_PWAIT;
            end
            S_PWAIT: begin
                if (lat_last) begin
                    addr_next = ram_dout;
                    if (ram_dout > RAM_TOP) begin
                        perr_next  = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        state_next = S_ACC;
                    end
                end else begin
                    cnt_next = cnt_reg + 2'd1;
                end
            end
            S_ACC: begin
                cnt_next   = 2'd0;
                state_next = we_reg ? S_DONE : S_RWAIT;
            end
            S_RWAIT: begin
                if (lat_last) begin
                    if (bit_reg)
                        rbit_next = ram_bout;
                    else
                        rdata_next = ram_dout;
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg + 2'd1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_comb begin
        ready_next    = (state_next == S_IDLE);
        done_next     = (state_next == S_DONE);
        err_next      = (state_next == S_DONE) && perr_next;
        cs_next       = 1'b1;
        rw_next       = 1'b1;
        bb_next       = bb_reg;
        ram_addr_next = ram_addr_reg;
        ram_pos_next  = ram_pos_reg;
        din_next      = din_reg;
        bin_next      = bin_reg;
        if (state_next == S_PTR) begin
            cs_next       = 1'b0;
            bb_next       = 1'b1;
            ram_addr_next = addr_next;
            ram_pos_next  = 8'hFF;
        end
        if (state_next == S_ACC) begin
            cs_next       = 1'b0;
            rw_next       = ~we_next;
            bb_next       = ~bit_next;
            ram_addr_next = addr_next;
            ram_pos_next  = pos_next;
            if (we_next) begin
                din_next = wdata_next;
                bin_next = wbit_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= 2'd0;
            we_reg       <= 1'b0;
            bit_reg      <= 1'b0;
            addr_reg     <= 8'h00;
            pos_reg      <= 8'h00;
            wdata_reg    <= 8'h00;
            wbit_reg     <= 1'b0;
            perr_reg     <= 1'b0;
            rdata_reg    <= 8'h00;
            rbit_reg     <= 1'b0;
            ready_reg    <= 1'b1;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            cs_reg       <= 1'b1;
            rw_reg       <= 1'b1;
            bb_reg       <= 1'b1;
            ram_addr_reg <= 8'h00;
            ram_pos_reg  <= 8'h00;
            din_reg      <= 8'h00;
            bin_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            we_reg       <= we_next;
            bit_reg      <= bit_next;
            addr_reg     <= addr_next;
            pos_reg      <= pos_next;
            wdata_reg    <= wdata_next;
            wbit_reg     <= wbit_next;
            perr_reg     <= perr_next;
            rdata_reg    <= rdata_next;
            rbit_reg     <= rbit_next;
            ready_reg    <= ready_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            cs_reg       <= cs_next;
            rw_reg       <= rw_next;
            bb_reg       <= bb_next;
            ram_addr_reg <= ram_addr_next;
            ram_pos_reg  <= ram_pos_next;
            din_reg      <= din_next;
            bin_reg      <= bin_next;
        end
    end

    assign ready    = ready_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign rdata    = rdata_reg;
    assign rbit     = rbit_reg;
    assign ram_cs   = cs_reg;
    assign ram_rw   = rw_reg;
    assign ram_bb   = bb_reg;
    assign ram_addr = ram_addr_reg;
    assign ram_pos  = ram_pos_reg;
    assign ram_din  = din_reg;
    assign ram_bin  = bin_reg;

endmodule
